// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: operation codes, the legal-code
// list and the result-buffer state encoding.
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SLL = 4'b0001,
    ALU_XOR = 4'b0100,
    ALU_SRL = 4'b0101,
    ALU_OR  = 4'b0110,
    ALU_AND = 4'b0111,
    ALU_SUB = 4'b1000,
    ALU_SRA = 4'b1101
  } alu_op_e;

  localparam int NUM_LEGAL = 8;

  localparam logic [3:0] LEGAL_OPS [NUM_LEGAL] = '{
    ALU_ADD, ALU_SLL, ALU_XOR, ALU_SRL,
    ALU_OR,  ALU_AND, ALU_SUB, ALU_SRA
  };

  typedef enum logic {
    ARB_EMPTY = 1'b0,
    ARB_FULL  = 1'b1
  } arb_state_e;

  // True when sel matches one of the implemented operation codes.
  function automatic logic is_legal_op(input logic [3:0] sel);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_LEGAL; i++) begin
      if (sel == LEGAL_OPS[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/alu_arb_alu.sv
// Purely combinational 32-bit ALU. Illegal codes produce a zero result and
// raise err, so the result is always a known value.
module alu_arb_alu
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [3:0]      sel,
  output logic [XLEN-1:0] rd,
  output logic            err
);

  logic [4:0] shamt;

  assign shamt = rs2[4:0];

  // Decode the operation; shifts use only the low five bits of rs2.
  always_comb begin
    rd  = '0;
    err = ~is_legal_op(sel);
    case (sel)
      ALU_ADD: rd = rs1 + rs2;
      ALU_SUB: rd = rs1 - rs2;
      ALU_SLL: rd = rs1 << shamt;
      ALU_SRL: rd = rs1 >> shamt;
      ALU_SRA: rd = $unsigned($signed(rs1) >>> shamt);
      ALU_XOR: rd = rs1 ^ rs2;
      ALU_OR:  rd = rs1 | rs2;
      ALU_AND: rd = rs1 & rs2;
      default: rd = '0;
    endcase
  end

endmodule

// File: rtl/alu_arb.sv
// Two-port arbiter in front of a shared ALU with a one-entry result buffer.
// A grant is issued only when the buffer can take the result, so a result is
// available one cycle after the transfer and full throughput is one per cycle.
//
// state     | meaning
// ----------+--------------------------------------------------
// ARB_EMPTY | buffer holds nothing, r_valid=0, any request accepted
// ARB_FULL  | buffer holds a result, r_valid=1, accept only with r_ready
module alu_arb
  import alu_pkg::*;
#(
  parameter int RR_EN = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             p0_valid,
  output logic             p0_ready,
  input  logic [XLEN-1:0]  p0_rs1,
  input  logic [XLEN-1:0]  p0_rs2,
  input  logic [3:0]       p0_sel,
  input  logic             p1_valid,
  output logic             p1_ready,
  input  logic [XLEN-1:0]  p1_rs1,
  input  logic [XLEN-1:0]  p1_rs2,
  input  logic [3:0]       p1_sel,
  output logic             r_valid,
  input  logic             r_ready,
  output logic [XLEN-1:0]  r_rd,
  output logic             r_id,
  output logic             r_err,
  output logic [CNT_W-1:0] op_cnt
);

  arb_state_e       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [XLEN-1:0]  r_rd_q, r_rd_d;
  logic             r_id_q, r_id_d;
  logic             r_err_q, r_err_d;
  logic [CNT_W-1:0] op_cnt_q, op_cnt_d;

  logic             accept;
  logic             grant;
  logic             xfer;
  logic             consume;
  logic [XLEN-1:0]  alu_rs1;
  logic [XLEN-1:0]  alu_rs2;
  logic [3:0]       alu_sel;
  logic [XLEN-1:0]  alu_rd;
  logic             alu_err;

  // Grant selection: a lone requester always wins; on contention either
  // alternate against the last accepted port or favour port 0.
  always_comb begin
    grant = 1'b0;
    if (p0_valid && p1_valid) begin
      grant = (RR_EN != 0) ? ~last_grant_q : 1'b0;
    end else begin
      grant = p1_valid;
    end
  end

  // Handshake: rst_n gates acceptance so nothing is taken during reset.
  always_comb begin
    accept   = (state_q == ARB_EMPTY) || r_ready;
    xfer     = rst_n && accept && (p0_valid || p1_valid);
    consume  = (state_q == ARB_FULL) && r_ready;
    p0_ready = xfer && (grant == 1'b0);
    p1_ready = xfer && (grant == 1'b1);
  end

  // Operand mux steered by the grant.
  always_comb begin
    alu_rs1 = grant ? p1_rs1 : p0_rs1;
    alu_rs2 = grant ? p1_rs2 : p0_rs2;
    alu_sel = grant ? p1_sel : p0_sel;
  end

  alu_arb_alu u_alu (
    .rs1 (alu_rs1),
    .rs2 (alu_rs2),
    .sel (alu_sel),
    .rd  (alu_rd),
    .err (alu_err)
  );

  // Next-state, result capture and consumed-result counter.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    r_rd_d       = r_rd_q;
    r_id_d       = r_id_q;
    r_err_d      = r_err_q;
    op_cnt_d     = op_cnt_q;

    case (state_q)
      ARB_EMPTY: if (xfer) state_d = ARB_FULL;
      ARB_FULL:  if (r_ready && !xfer) state_d = ARB_EMPTY;
      default:   state_d = ARB_EMPTY;
    endcase

    if (xfer) begin
      last_grant_d = grant;
      r_rd_d       = alu_rd;
      r_id_d       = grant;
      r_err_d      = alu_err;
    end

    if (consume) op_cnt_d = op_cnt_q + CNT_W'(1);
  end

  // State registers with synchronous active-low reset; last_grant starts at 1
  // so port 0 wins the first contended cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ARB_EMPTY;
      last_grant_q <= 1'b1;
      r_rd_q       <= '0;
      r_id_q       <= 1'b0;
      r_err_q      <= 1'b0;
      op_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      r_rd_q       <= r_rd_d;
      r_id_q       <= r_id_d;
      r_err_q      <= r_err_d;
      op_cnt_q     <= op_cnt_d;
    end
  end

  assign r_valid = (state_q == ARB_FULL);
  assign r_rd    = r_rd_q;
  assign r_id    = r_id_q;
  assign r_err   = r_err_q;
  assign op_cnt  = op_cnt_q;

endmodule
